// File: rtl/alu_spi_master.sv
// Processor-side SPI master for the serial ALU.
// Sends {op_2, op_1, op_code} LSB first, then collects the result from MISO.
module alu_spi_master #(
  parameter int REGISTER_SIZE = 8,
  parameter int OPCODE_WIDTH  = 2,
  parameter int WAIT_TIMEOUT  = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [OPCODE_WIDTH-1:0]  i_op_code,
  input  logic [REGISTER_SIZE-1:0] i_op_1,
  input  logic [REGISTER_SIZE-1:0] i_op_2,
  output logic                     o_result_valid,
  output logic [REGISTER_SIZE-1:0] o_result,
  output logic                     o_error,
  output logic                     o_nss,
  output logic                     o_mosi,
  input  logic                     i_miso
);

  localparam int P  = 2*REGISTER_SIZE + OPCODE_WIDTH;
  localparam int CW = $clog2(P);
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_TX   = CW'(P - 1);
  localparam logic [CW-1:0] LAST_RX   = CW'(REGISTER_SIZE - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_SEND,
    S_WAIT, S_RECV, S_DONE, S_ERROR
  } state_t;

  state_t                   r_state;
  logic [P-1:0]             r_packet;
  logic [CW-1:0]            r_bit_cnt;
  logic [WW-1:0]            r_wait_cnt;
  logic [REGISTER_SIZE-1:0] r_shift;
  logic [REGISTER_SIZE-1:0] r_result;
  logic                     r_ready;
  logic                     r_result_valid;
  logic                     r_error;
  logic                     r_nss;
  logic                     r_mosi;
  logic                     w_accept;

  assign w_accept = i_valid && r_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_packet       <= '0;
      r_bit_cnt      <= '0;
      r_wait_cnt     <= '0;
      r_shift        <= '0;
      r_result       <= '0;
      r_ready        <= 1'b1;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_nss          <= 1'b1;
      r_mosi         <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_packet  <= {i_op_2, i_op_1, i_op_code};
            r_state   <= S_SELECT;
            r_ready   <= 1'b0;
            r_nss     <= 1'b0;
            r_mosi    <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        S_SELECT: begin
          r_state <= S_START;
          r_mosi  <= 1'b1;
        end
        // Packet shifts right so bit 0 always holds the next bit to send.
        S_START: begin
          r_state   <= S_SEND;
          r_mosi    <= r_packet[0];
          r_packet  <= {1'b0, r_packet[P-1:1]};
          r_bit_cnt <= '0;
        end
        S_SEND: begin
          if (r_bit_cnt == LAST_TX) begin
            r_state    <= S_WAIT;
            r_mosi     <= 1'b0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
          end else begin
            r_mosi    <= r_packet[0];
            r_packet  <= {1'b0, r_packet[P-1:1]};
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (i_miso) begin
            r_state   <= S_RECV;
            r_bit_cnt <= '0;
          end else if (r_wait_cnt == LAST_WAIT) begin
            r_state <= S_ERROR;
            r_nss   <= 1'b1;
            r_error <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
        S_RECV: begin
          r_shift <= {i_miso, r_shift[REGISTER_SIZE-1:1]};
          if (r_bit_cnt == LAST_RX) begin
            r_state        <= S_DONE;
            r_nss          <= 1'b1;
            r_result       <= {i_miso, r_shift[REGISTER_SIZE-1:1]};
            r_result_valid <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_DONE, S_ERROR: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready        = r_ready;
  assign o_result_valid = r_result_valid;
  assign o_result       = r_result;
  assign o_error        = r_error;
  assign o_nss          = r_nss;
  assign o_mosi         = r_mosi;

endmodule

// File: tb/tb_alu_spi_master.sv
// Bench for alu_spi_master: behavioural ALU slave, cycle-level model
// of the master's outputs, and directed operations with literal results.
module tb_alu_spi_master;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [1:0] i_op_code = '0;
  logic [7:0] i_op_1 = '0;
  logic [7:0] i_op_2 = '0;
  logic       o_result_valid;
  logic [7:0] o_result;
  logic       o_error;
  logic       o_nss;
  logic       o_mosi;
  logic       i_miso;

  int n_tests = 0;
  int n_fail  = 0;
  bit alu_en  = 1'b1;

  always #5 clk = ~clk;

  alu_spi_master dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op_code(i_op_code), .i_op_1(i_op_1), .i_op_2(i_op_2),
    .o_result_valid(o_result_valid), .o_result(o_result),
    .o_error(o_error), .o_nss(o_nss), .o_mosi(o_mosi),
    .i_miso(i_miso)
  );

  function automatic logic [7:0] alu_fn(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ALU slave: acts on what it sees each cycle, drives MISO for that cycle.
  int         a_mode = 0;
  int         a_cnt  = 0;
  logic [17:0] a_pkt = '0;
  logic [7:0]  a_res = '0;
  initial begin
    i_miso = 1'b0;
    forever begin
      @(negedge clk);
      if (i_reset || !alu_en || o_nss) begin
        a_mode = 0;
        i_miso = 1'b0;
      end else begin
        case (a_mode)
          0: begin
            i_miso = 1'b0;
            if (o_mosi) begin a_mode = 1; a_cnt = 0; end
          end
          1: begin
            i_miso = 1'b0;
            a_pkt[a_cnt] = o_mosi;
            a_cnt++;
            if (a_cnt == 18) a_mode = 2;
          end
          2: begin i_miso = 1'b0; a_mode = 3; end
          3: begin
            i_miso = 1'b1;
            a_res  = alu_fn(a_pkt[1:0], a_pkt[9:2], a_pkt[17:10]);
            a_cnt  = 0;
            a_mode = 4;
          end
          default: begin
            i_miso = a_res[a_cnt];
            a_cnt++;
            if (a_cnt == 8) a_mode = 0;
          end
        endcase
      end
    end
  end

  // Model: ph = cycles since accept (0 = idle); transaction ends at 31
  // with a result, or at 37 when no ack ever arrives.
  int          ph = 0;
  bit          started = 1'b0;
  bit          m_alu = 1'b1;
  logic [17:0] m_pkt = '0;
  logic [7:0]  m_res = '0;
  logic [7:0]  m_exp_result = '0;
  always @(negedge clk) begin : model
    int endc;
    endc = m_alu ? 31 : 37;
    if (started) begin
      if (m_alu && ph == 31) m_exp_result = m_res;
      chk("ready", o_ready, ph == 0);
      chk("nss", o_nss, ph == 0 || ph == endc);
      chk("mosi", o_mosi,
          ph == 2 ? 1'b1 :
          (ph >= 3 && ph <= 20) ? m_pkt[ph-3] : 1'b0);
      chk("result_valid", o_result_valid, m_alu && ph == 31);
      chk("error", o_error, !m_alu && ph == 37);
      chk("result", o_result, m_exp_result);
    end
    if (i_reset) begin
      started = 1'b1;
      ph = 0;
      m_exp_result = '0;
    end else if (started) begin
      if (ph == 0) begin
        if (i_valid) begin
          ph    = 1;
          m_pkt = {i_op_2, i_op_1, i_op_code};
          m_res = alu_fn(i_op_code, i_op_1, i_op_2);
          m_alu = alu_en;
        end
      end else if (ph == endc) begin
        ph = 0;
      end else begin
        ph++;
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 100 && !o_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("ready_wait", o_ready, 1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_r, input int exp_lat,
                        input bit noise);
    int lat;
    wait_ready();
    i_op_code = op; i_op_1 = a; i_op_2 = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (noise && c == 5) begin
        i_valid = 1'b1;
        i_op_code = op ^ 2'b10; i_op_1 = ~a; i_op_2 = b + 8'd1;
      end
      if (noise && c == 26) i_valid = 1'b0;
      if (o_result_valid || o_error) begin lat = c; break; end
      @(posedge clk); #1;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_error"}, o_error, exp_lat == 37);
    chk({nm, "_valid"}, o_result_valid, exp_lat != 37);
    chk({nm, "_nss"}, o_nss, 1);
    chk({nm, "_result"}, o_result, exp_r);
    @(posedge clk); #1;
    chk({nm, "_ready_after"}, o_ready, 1);
  endtask

  initial begin : stim
    logic [1:0] bop [3];
    logic [7:0] ba [3];
    logic [7:0] bb [3];
    int idx, last, cyc;
    bit rdy;
    bop = '{2'd0, 2'd1, 2'd3};
    ba  = '{8'h0A, 8'h10, 8'hA0};
    bb  = '{8'h14, 8'h01, 8'h05};

    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    chk("rst_nss", o_nss, 1);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_result", o_result, 0);
    chk("rst_valid", o_result_valid, 0);
    chk("rst_error", o_error, 0);

    run_op("add", 2'd0, 8'h05, 8'h03, 8'h08, 31, 1'b0);
    chk("add_packet", m_pkt, 18'h00C14);
    run_op("sub", 2'd1, 8'h03, 8'h05, 8'hFE, 31, 1'b0);
    run_op("and", 2'd2, 8'hF0, 8'h3C, 8'h30, 31, 1'b0);
    run_op("or",  2'd3, 8'hF0, 8'h0F, 8'hFF, 31, 1'b0);
    run_op("busy_ignore", 2'd0, 8'h22, 8'h11, 8'h33, 31, 1'b1);

    wait_ready();
    idx = 0; last = 0; cyc = 0;
    i_op_code = bop[0]; i_op_1 = ba[0]; i_op_2 = bb[0];
    i_valid = 1'b1;
    for (int c = 0; c < 200 && idx < 3; c++) begin
      rdy = o_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        if (idx > 0) chk("b2b_gap", cyc - last, 32);
        last = cyc;
        idx++;
        if (idx < 3) begin
          i_op_code = bop[idx]; i_op_1 = ba[idx]; i_op_2 = bb[idx];
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", idx, 3);
    for (int c = 0; c < 40 && !o_result_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("b2b_last_valid", o_result_valid, 1);
    chk("b2b_last_result", o_result, 8'hA5);

    alu_en = 1'b0;
    run_op("timeout", 2'd0, 8'h07, 8'h07, 8'hA5, 37, 1'b0);
    alu_en = 1'b1;

    wait_ready();
    i_op_code = 2'd0; i_op_1 = 8'h40; i_op_2 = 8'h40; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    chk("midrst_nss", o_nss, 1);
    chk("midrst_mosi", o_mosi, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_result_valid, 0);
    chk("midrst_error", o_error, 0);
    chk("midrst_result", o_result, 0);
    run_op("post_rst_add", 2'd0, 8'h01, 8'h01, 8'h02, 31, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
